// File: rtl/vram_arbiter_pkg.sv
// Shared VGA/framebuffer constants, address helper and clear-FSM states.
// Imported by the arbiter, its clear engine and the bench.
`timescale 1ns/1ps
package vram_arbiter_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int H_TOTAL    = 800;
  localparam int V_ACTIVE   = 480;
  localparam int V_TOTAL    = 525;
  localparam int SCALE_LOG2 = 2;
  localparam int FB_W       = H_ACTIVE >> SCALE_LOG2;
  localparam int FB_H       = V_ACTIVE >> SCALE_LOG2;
  localparam int PIX_W      = 8;
  localparam int AW         = 15;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } clr_state_t;

  // y*160 + x as two shifts; only valid for the 160-wide framebuffer
  function automatic logic [AW-1:0] fb_addr(
    input logic [9:0] x,
    input logic [9:0] y
  );
    logic [AW-1:0] w_y;
    w_y = AW'(y);
    return (w_y << 7) + (w_y << 5) + AW'(x);
  endfunction

endpackage

// File: rtl/vram_arbiter_clear.sv
// Full-framebuffer clear engine: owns the sweep counter, fill colour
// and busy flag, stepping one word per free RAM slot.
`timescale 1ns/1ps
module vram_arbiter_clear #(
  parameter int AW      = 15,
  parameter int PIX_W   = 8,
  parameter int N_WORDS = 19200
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_start,
  input  logic [PIX_W-1:0] i_color,
  input  logic             i_slot_free,
  output logic             o_busy,
  output logic [AW-1:0]    o_addr,
  output logic [PIX_W-1:0] o_color
);
  import vram_arbiter_pkg::*;

  localparam logic [AW-1:0] LAST = AW'(N_WORDS - 1);

  clr_state_t       r_state;
  clr_state_t       w_next;
  logic [AW-1:0]    r_cnt;
  logic [PIX_W-1:0] r_color;
  logic             w_step;
  logic             w_done;

  assign w_step = (r_state == S_CLEAR) && i_slot_free;
  assign w_done = w_step && (r_cnt == LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_CLEAR;
      S_CLEAR: if (w_done)  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_color <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_start) begin
        r_cnt   <= '0;
        r_color <= i_color;
      end else if (w_step) begin
        r_cnt <= w_done ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign o_busy  = (r_state == S_CLEAR);
  assign o_addr  = r_cnt;
  assign o_color = r_color;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads own every 4th active
// pixel; writer and clear engine share the remaining slots.
`timescale 1ns/1ps
module vram_arbiter #(
  parameter int FB_W          = vram_arbiter_pkg::FB_W,
  parameter int FB_H          = vram_arbiter_pkg::FB_H,
  parameter int SCALE_LOG2    = vram_arbiter_pkg::SCALE_LOG2,
  parameter int PIX_W         = vram_arbiter_pkg::PIX_W,
  parameter int AW            = vram_arbiter_pkg::AW,
  parameter bit WR_BLANK_ONLY = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [9:0]       h,
  input  logic [9:0]       v,
  input  logic             von,
  input  logic             wr_req,
  input  logic [7:0]       wr_x,
  input  logic [6:0]       wr_y,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ack,
  input  logic             clr_req,
  input  logic [PIX_W-1:0] clr_color,
  output logic             clr_busy,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_we,
  output logic [PIX_W-1:0] ram_wdata,
  input  logic [PIX_W-1:0] ram_rdata,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_valid
);
  import vram_arbiter_pkg::*;

  logic             w_disp_slot;
  logic             w_slot_free;
  logic             w_in_range;
  logic             w_busy;
  logic [AW-1:0]    w_disp_addr;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_clr_addr;
  logic [PIX_W-1:0] w_clr_color;
  logic             r_rd_pend;
  logic             r_von_d1;
  logic             r_von_d2;
  logic [PIX_W-1:0] r_pix;

  assign w_disp_slot = von && (h[SCALE_LOG2-1:0] == '0);
  assign w_slot_free = !w_disp_slot && (!WR_BLANK_ONLY || !von);
  assign w_in_range  = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);

  if (FB_W == 160) begin : g_shift
    assign w_disp_addr = AW'(fb_addr(h >> SCALE_LOG2, v >> SCALE_LOG2));
    assign w_wr_addr   = AW'(fb_addr(10'(wr_x), 10'(wr_y)));
  end else begin : g_mul
    assign w_disp_addr = AW'(v >> SCALE_LOG2) * AW'(FB_W)
                       + AW'(h >> SCALE_LOG2);
    assign w_wr_addr   = AW'(wr_y) * AW'(FB_W) + AW'(wr_x);
  end

  vram_arbiter_clear #(
    .AW      (AW),
    .PIX_W   (PIX_W),
    .N_WORDS (FB_W * FB_H)
  ) u_clear (
    .clk         (clk),
    .clr         (clr),
    .i_start     (clr_req),
    .i_color     (clr_color),
    .i_slot_free (w_slot_free),
    .o_busy      (w_busy),
    .o_addr      (w_clr_addr),
    .o_color     (w_clr_color)
  );

  // A pending clr_req blocks the writer so it is never acked alongside it
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    wr_ack    = 1'b0;
    if (!clr) begin
      if (w_disp_slot) begin
        ram_addr = w_disp_addr;
      end else if (w_slot_free) begin
        if (w_busy) begin
          ram_addr  = w_clr_addr;
          ram_we    = 1'b1;
          ram_wdata = w_clr_color;
        end else if (wr_req && !clr_req) begin
          wr_ack = 1'b1;
          if (w_in_range) begin
            ram_addr  = w_wr_addr;
            ram_we    = 1'b1;
            ram_wdata = wr_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_rd_pend <= 1'b0;
      r_von_d1  <= 1'b0;
      r_von_d2  <= 1'b0;
      r_pix     <= '0;
    end else begin
      r_rd_pend <= w_disp_slot;
      r_von_d1  <= von;
      r_von_d2  <= r_von_d1;
      if (r_rd_pend) r_pix <= ram_rdata;
    end
  end

  assign pix_valid = r_von_d2;
  assign pix_data  = r_von_d2 ? r_pix : '0;
  assign clr_busy  = w_busy && !clr;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed timing/write/clear vectors,
// expected pixels and acks queued at issue, checked by a negedge monitor.
`timescale 1ns/1ps
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } ack_t;

  logic          clk = 1'b0;
  logic          clr;
  logic [9:0]    h, v;
  logic          von;
  logic          wr_req, wr_req_b;
  logic [7:0]    wr_x;
  logic [6:0]    wr_y;
  logic [7:0]    wr_data;
  logic          wr_ack, wr_ack_b;
  logic          clr_req, clr_req_b;
  logic [7:0]    clr_color;
  logic          clr_busy, clr_busy_b;
  logic [AW-1:0] ram_addr, ram_addr_b;
  logic          ram_we, ram_we_b;
  logic [7:0]    ram_wdata, ram_wdata_b;
  logic [7:0]    ram_rdata;
  logic [7:0]    pix_data, pix_data_b;
  logic          pix_valid, pix_valid_b;

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] exp_pix [$];
  ack_t       exp_ack [$];
  ack_t       mon_e;
  logic [7:0] mon_p;
  logic       vh1, vh2;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         clr_seen = 0;
  int         last_ack_cyc = 0;
  int         drop_cyc = 0;
  logic [7:0] clr_exp_color = 8'h00;

  always #20 clk = ~clk;

  vram_arbiter u_dut (
    .clk(clk), .clr(clr), .h(h), .v(v), .von(von),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ack(wr_ack), .clr_req(clr_req), .clr_color(clr_color),
    .clr_busy(clr_busy), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid)
  );

  vram_arbiter #(.WR_BLANK_ONLY(1'b1)) u_dut_b (
    .clk(clk), .clr(clr), .h(h), .v(v), .von(von),
    .wr_req(wr_req_b), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ack(wr_ack_b), .clr_req(clr_req_b), .clr_color(clr_color),
    .clr_busy(clr_busy_b), .ram_addr(ram_addr_b), .ram_we(ram_we_b),
    .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata),
    .pix_data(pix_data_b), .pix_valid(pix_valid_b)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    cyc <= cyc + 1;
    if (clr) begin
      vh1 <= 1'b0;
      vh2 <= 1'b0;
    end else begin
      vh1 <= von;
      vh2 <= vh1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      chk("pix_valid_lag", int'(pix_valid), int'(vh2));
      chk("pix_valid_b_lag", int'(pix_valid_b), int'(vh2));
      if (pix_valid) begin
        if (exp_pix.size() == 0) begin
          chk("pix_unexpected", 1, 0);
        end else begin
          mon_p = exp_pix.pop_front();
          chk("pix_data", int'(pix_data), int'(mon_p));
          chk("pix_data_b", int'(pix_data_b), int'(mon_p));
        end
      end
      if (von && h[1:0] == 2'b00) begin
        chk("disp_addr", int'(ram_addr),
            int'(v >> 2) * FB_W + int'(h >> 2));
        chk("disp_we", int'(ram_we), 0);
      end
      if (wr_ack) begin
        last_ack_cyc = cyc;
        chk("ack_on_disp_slot", int'(von && h[1:0] == 2'b00), 0);
        chk("ack_during_clear", int'(clr_busy), 0);
        if (exp_ack.size() == 0) begin
          chk("ack_unexpected", 1, 0);
        end else begin
          mon_e = exp_ack.pop_front();
          chk("ack_we", int'(ram_we), int'(mon_e.we));
          chk("ack_addr", int'(ram_addr), int'(mon_e.addr));
          chk("ack_wdata", int'(ram_wdata), int'(mon_e.data));
        end
      end
      if (wr_ack_b) chk("ack_b_in_active", int'(von), 0);
      if (ram_we && clr_busy) begin
        chk("clr_addr", int'(ram_addr), clr_seen);
        chk("clr_data", int'(ram_wdata), int'(clr_exp_color));
        clr_seen++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_active(input int v0, input int nl,
                            input int hw, input int hb);
    for (int l = 0; l < nl; l++) begin
      for (int hh = 0; hh < hw; hh++) begin
        h   = 10'(hh);
        v   = 10'(v0 + l);
        von = 1'b1;
        exp_pix.push_back(8'((((v0 + l) >> 2) * FB_W + (hh >> 2)) & 255));
        step();
      end
      von = 1'b0;
      h   = '0;
      repeat (hb) step();
    end
  endtask

  task automatic do_write(input int x, input int y,
                          input int d, input int budget);
    ack_t e;
    bit   ok;
    bit   got;
    ok     = (x < FB_W) && (y < FB_H);
    e.we   = ok;
    e.addr = ok ? AW'(y * FB_W + x) : '0;
    e.data = ok ? d[7:0] : 8'h00;
    exp_ack.push_back(e);
    wr_x    = x[7:0];
    wr_y    = y[6:0];
    wr_data = d[7:0];
    wr_req  = 1'b1;
    got     = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ack_timeout", 0, 1);
    step();
    wr_req = 1'b0;
  endtask

  initial begin
    repeat (H_TOTAL * V_TOTAL / 5) @(posedge clk);
    $display("FAIL watchdog: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit prev_von;
    bit got;
    int bad;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i);
    clr = 1'b1; h = '0; v = '0; von = 1'b1;
    wr_req = 1'b1; wr_req_b = 1'b0; wr_x = 8'd1; wr_y = 7'd1;
    wr_data = 8'h99; clr_req = 1'b1; clr_req_b = 1'b0;
    clr_color = 8'h42;
    repeat (3) step();
    @(negedge clk);
    chk("rst_wr_ack", int'(wr_ack), 0);
    chk("rst_clr_busy", int'(clr_busy), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_ram_wdata", int'(ram_wdata), 0);
    chk("rst_pix_data", int'(pix_data), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    step();
    clr = 1'b0; von = 1'b0; wr_req = 1'b0; clr_req = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(clr_busy), 0);
    step();

    // 1: display scan of lines 4..7; (h=8,v=4) reads word 162
    run_active(4, 4, 16, 8);

    // 2: held write during active video, addr 485
    fork
      run_active(20, 2, 16, 4);
      do_write(5, 3, 8'hAA, 100);
    join
    chk("t2_ram485", int'(mem[485]), 8'hAA);

    // 3: blank-only instance, request raised mid-line
    wr_x = 8'd9; wr_y = 7'd4; wr_data = 8'h3C;
    fork
      run_active(24, 1, 16, H_TOTAL - H_ACTIVE);
      begin
        repeat (6) step();
        wr_req_b = 1'b1;
        prev_von = 1'b1;
        got      = 1'b0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (wr_ack_b) begin
            got = 1'b1;
            chk("t3_ack_von", int'(von), 0);
            chk("t3_first_blank", int'(prev_von), 1);
            chk("t3_we", int'(ram_we_b), 1);
            chk("t3_addr", int'(ram_addr_b), 4 * FB_W + 9);
            chk("t3_wdata", int'(ram_wdata_b), 8'h3C);
            chk("t3_busy_b", int'(clr_busy_b), 0);
            break;
          end
          prev_von = von;
        end
        if (!got) chk("t3_ack_timeout", 0, 1);
        step();
        wr_req_b = 1'b0;
      end
    join

    // 4: clear to 0x1F with a colliding write
    clr_seen      = 0;
    clr_exp_color = 8'h1F;
    fork
      begin
        clr_req   = 1'b1;
        clr_color = 8'h1F;
        @(negedge clk);
        chk("t4_no_ack_on_accept", int'(wr_ack), 0);
        chk("t4_busy_on_accept", int'(clr_busy), 0);
        step();
        clr_req = 1'b0;
        @(negedge clk);
        chk("t4_busy", int'(clr_busy), 1);
        got = 1'b0;
        for (int i = 0; i < FB_W * FB_H + 100; i++) begin
          @(negedge clk);
          if (!clr_busy) begin
            got = 1'b1;
            break;
          end
        end
        if (!got) chk("t4_busy_timeout", 0, 1);
        drop_cyc = cyc;
        chk("t4_clear_count", clr_seen, FB_W * FB_H);
        bad = 0;
        for (int i = 0; i < FB_W * FB_H; i++)
          if (mem[i] != 8'h1F) bad++;
        chk("t4_fill_bad_words", bad, 0);
      end
      do_write(7, 2, 8'h55, FB_W * FB_H + 200);
    join
    chk("t4_ack_after_clear", int'(last_ack_cyc >= drop_cyc), 1);
    chk("t4_write_landed", int'(mem[2 * FB_W + 7]), 8'h55);

    // 5: out-of-range write is dropped, then reset aborts a clear
    do_write(200, 3, 8'h77, 20);
    chk("t5_ram680", int'(mem[3 * FB_W + 200]), 8'h1F);
    clr_seen      = 0;
    clr_exp_color = 8'hC3;
    clr_req   = 1'b1;
    clr_color = 8'hC3;
    step();
    clr_req = 1'b0;
    repeat (50) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("t5_busy", int'(clr_busy), 0);
    chk("t5_we", int'(ram_we), 0);
    chk("t5_addr", int'(ram_addr), 0);
    chk("t5_wdata", int'(ram_wdata), 0);
    chk("t5_ack", int'(wr_ack), 0);
    chk("t5_pix_valid", int'(pix_valid), 0);
    chk("t5_pix_data", int'(pix_data), 0);
    repeat (5) step();
    @(negedge clk);
    chk("t5_still_idle", int'(clr_busy), 0);
    chk("t5_untouched", int'(mem[1000]), 8'h1F);
    chk("t5_first_cleared", int'(mem[0]), 8'hC3);

    repeat (4) step();
    chk("pix_queue_empty", exp_pix.size(), 0);
    chk("ack_queue_empty", exp_ack.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
